// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the sync generator, colour generator and benches.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned CNT_W    = 10;
  localparam logic        SYNC_POL = 1'b0;

  // Per-axis decode of the value a counter is about to load.
  typedef struct packed {
    logic wrap;
    logic in_sync;
    logic in_visible;
  } axis_flags_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter plus sync/visible decode of its next value.
module vga_axis_counter #(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  parameter int unsigned VISIBLE    = 640,
  parameter int unsigned CNT_W      = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             in_sync,
  output logic             in_visible
);

  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SyncFirst = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SyncLast  = CNT_W'(SYNC_START + SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] VisEnd    = CNT_W'(VISIBLE);

  logic [CNT_W-1:0] count_d;

  always_comb begin
    wrap    = en && (count == LastCnt);
    count_d = count;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count + CNT_W'(1);
    end
  end

  // Flags describe count_d so the top can register them alongside the counter.
  always_comb begin
    in_sync    = (count_d >= SyncFirst) && (count_d <= SyncLast);
    in_visible = (count_d < VisEnd);
  end

  // Reset parks the counter at its last value so the first enable wraps to 0.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= LastCnt;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: two chained axis counters with registered sync, blanking and start pulses.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
  parameter logic        SYNC_POL  = vga_timing_pkg::SYNC_POL,
  parameter int unsigned CNT_W     = vga_timing_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
);

  import vga_timing_pkg::axis_flags_t;

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  axis_flags_t h_flags;
  axis_flags_t v_flags;
  logic        v_en;

  logic hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;

  assign v_en = pix_en & h_flags.wrap;

  vga_axis_counter #(
    .TOTAL      (HTotal),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .VISIBLE    (H_VISIBLE),
    .CNT_W      (CNT_W)
  ) u_h_axis (
    .clk        (clk),
    .clr        (clr),
    .en         (pix_en),
    .count      (hcount),
    .wrap       (h_flags.wrap),
    .in_sync    (h_flags.in_sync),
    .in_visible (h_flags.in_visible)
  );

  vga_axis_counter #(
    .TOTAL      (VTotal),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .VISIBLE    (V_VISIBLE),
    .CNT_W      (CNT_W)
  ) u_v_axis (
    .clk        (clk),
    .clr        (clr),
    .en         (v_en),
    .count      (vcount),
    .wrap       (v_flags.wrap),
    .in_sync    (v_flags.in_sync),
    .in_visible (v_flags.in_visible)
  );

  // v_flags.wrap already implies a horizontal wrap, so frame_start implies line_start.
  always_comb begin
    hsync_d       = h_flags.in_sync ? SYNC_POL : ~SYNC_POL;
    vsync_d       = v_flags.in_sync ? SYNC_POL : ~SYNC_POL;
    video_on_d    = h_flags.in_visible & v_flags.in_visible;
    line_start_d  = h_flags.wrap;
    frame_start_d = h_flags.wrap & v_flags.wrap;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      video_on    <= video_on_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

endmodule
